// File: rtl/vc_pkg.sv
// Shared victim-cache constants and types.
package vc_pkg;
  localparam int VC_ENTRIES = 4;
  localparam int VC_IDX_W   = $clog2(VC_ENTRIES);
  localparam int VC_TAG_W   = 26;
  localparam int VC_DATA_W  = 64;

  typedef logic [VC_IDX_W-1:0]   vc_idx_t;
  typedef logic [VC_ENTRIES-1:0] vc_mask_t;
endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder, gated by an enable.
module onehot_dec #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);
  for (genvar g = 0; g < N; g++) begin : g_dec
    assign onehot_o[g] = en_i && (idx_i == IDX_W'(g));
  end
endmodule

// File: rtl/victim_fill_demux.sv
// Routes one evicted L1 line per cycle into a victim-cache entry and tracks
// which entries hold valid lines.
module victim_fill_demux
  import vc_pkg::*;
#(
  parameter int ENTRIES = VC_ENTRIES,
  parameter int TAG_W   = VC_TAG_W,
  parameter int DATA_W  = VC_DATA_W,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_sel_en,
  input  logic [IDX_W-1:0]   in_sel,
  input  logic               stall,
  input  logic               inv_en,
  input  logic [IDX_W-1:0]   inv_idx,
  output logic [ENTRIES-1:0] out_we,
  output logic [IDX_W-1:0]   out_idx,
  output logic [TAG_W-1:0]   out_tag,
  output logic [DATA_W-1:0]  out_data,
  output logic [ENTRIES-1:0] valid_mask,
  output logic [IDX_W-1:0]   rr_ptr,
  output logic               full
);
  logic               accept;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   dest;
  logic               use_rr;
  logic [ENTRIES-1:0] set_mask, clr_mask;

  logic [ENTRIES-1:0] we_q, valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, rr_q, rr_d;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  data_q;

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  // Lowest-index invalid entry; scanning downward leaves the lowest hit last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    use_rr = 1'b0;
    if (in_sel_en)       dest = in_sel;
    else if (free_found) dest = free_idx;
    else begin
      dest   = rr_q;
      use_rr = accept;
    end
  end

  onehot_dec #(.N(ENTRIES), .IDX_W(IDX_W)) u_set_dec (
    .idx_i(dest), .en_i(accept), .onehot_o(set_mask)
  );

  onehot_dec #(.N(ENTRIES), .IDX_W(IDX_W)) u_clr_dec (
    .idx_i(inv_idx), .en_i(inv_en), .onehot_o(clr_mask)
  );

  // Set applied after clear so a same-index write beats the invalidate.
  assign valid_d = (valid_q & ~clr_mask) | set_mask;
  // ENTRIES is a power of two, so natural overflow wraps the pointer.
  assign rr_d    = use_rr ? rr_q + IDX_W'(1) : rr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      we_q    <= set_mask;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      if (accept) begin
        idx_q  <= dest;
        tag_q  <= in_tag;
        data_q <= in_data;
      end
    end
  end

  assign out_we     = we_q;
  assign out_idx    = idx_q;
  assign out_tag    = tag_q;
  assign out_data   = data_q;
  assign valid_mask = valid_q;
  assign rr_ptr     = rr_q;
  assign full       = &valid_q;
endmodule

// File: tb/tb_victim_fill_demux.sv
// Randomized and directed bench for victim_fill_demux against a behavioural model.
module tb_victim_fill_demux;
  localparam int E      = 4;
  localparam int IW     = 2;
  localparam int TW     = 26;
  localparam int DW     = 64;
  localparam int SNAP_W = E + IW + TW + DW + E + IW + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tag = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_sel_en = 1'b0;
  logic [IW-1:0] in_sel = '0;
  logic          stall = 1'b0;
  logic          inv_en = 1'b0;
  logic [IW-1:0] inv_idx = '0;
  logic [E-1:0]  out_we;
  logic [IW-1:0] out_idx;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
  logic [E-1:0]  valid_mask;
  logic [IW-1:0] rr_ptr;
  logic          full;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  bit            mv[E];
  int            mrr;
  logic [E-1:0]  m_we;
  int            m_idx;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;

  victim_fill_demux #(.ENTRIES(E), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_data(in_data), .in_sel_en(in_sel_en), .in_sel(in_sel),
    .stall(stall), .inv_en(inv_en), .inv_idx(inv_idx), .out_we(out_we),
    .out_idx(out_idx), .out_tag(out_tag), .out_data(out_data),
    .valid_mask(valid_mask), .rr_ptr(rr_ptr), .full(full)
  );

  always #5 clk = ~clk;

  wire [SNAP_W-1:0] dut_snap = {out_we, out_idx, out_tag, out_data, valid_mask, rr_ptr, full};

  function automatic logic [SNAP_W-1:0] exp_snap();
    logic [E-1:0] m;
    for (int i = 0; i < E; i++) m[i] = mv[i];
    return {m_we, IW'(m_idx), m_tag, m_data, m, IW'(mrr), &m};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < E; i++) mv[i] = 0;
    mrr = 0; m_we = '0; m_idx = 0; m_tag = '0; m_data = '0;
  endtask

  // Predict the effect of the inputs currently driven, as of the next edge.
  task automatic model_step();
    int dest;
    bit acc;
    bit from_rr;
    acc = in_valid && !stall;
    dest = -1;
    from_rr = 0;
    if (acc) begin
      if (in_sel_en) dest = int'(in_sel);
      else begin
        for (int i = 0; i < E; i++) if (!mv[i] && dest < 0) dest = i;
        if (dest < 0) begin dest = mrr; from_rr = 1; end
      end
    end
    if (inv_en) mv[inv_idx] = 0;
    m_we = '0;
    if (acc) begin
      mv[dest] = 1; m_we[dest] = 1'b1;
      m_idx = dest; m_tag = in_tag; m_data = in_data;
    end
    if (from_rr) mrr = (mrr + 1) % E;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [TW-1:0] tag);
    in_valid = 1'b1; in_sel_en = 1'b0; in_tag = tag;
    in_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #12;
    total++;
    if (dut_snap !== '0 || in_ready !== 1'b1) begin
      $display("FAIL reset: outputs=%h ready=%b expected all zero, ready=1", dut_snap, in_ready);
    end else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill4();
    logic [TW-1:0] tags[4];
    tags = '{26'h11, 26'h22, 26'h33, 26'h44};
    for (int k = 0; k < 4; k++) begin
      fill(tags[k]);
      tick();
      total++;
      if (out_we !== E'(1 << k) || out_tag !== tags[k] || dut_snap !== exp_snap()) begin
        $display("FAIL fill4[%0d]: we=%b tag=%h snap=%h expected we=%b tag=%h snap=%h",
                 k, out_we, out_tag, dut_snap, E'(1 << k), tags[k], exp_snap());
      end else passed++;
    end
    in_valid = 1'b0;
    total++;
    if (full !== 1'b1 || rr_ptr !== '0) begin
      $display("FAIL fill4_full: full=%b rr=%0d expected full=1 rr=0", full, rr_ptr);
    end else passed++;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      fill(TW'(26'h100 + k));
      tick();
      total++;
      if (out_idx !== IW'(k % 4) || out_we !== E'(1 << (k % 4)) ||
          rr_ptr !== IW'((k + 1) % 4) || dut_snap !== exp_snap()) begin
        $display("FAIL wrap[%0d]: idx=%0d we=%b rr=%0d expected idx=%0d we=%b rr=%0d",
                 k, out_idx, out_we, rr_ptr, k % 4, E'(1 << (k % 4)), (k + 1) % 4);
      end else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_inv_fill();
    logic [IW-1:0] rr_before;
    rr_before = rr_ptr;
    in_valid = 1'b0; inv_en = 1'b1; inv_idx = 2'd2;
    tick();
    inv_en = 1'b0;
    total++;
    if (valid_mask !== 4'b1011 || out_we !== '0) begin
      $display("FAIL inv: mask=%b we=%b expected mask=1011 we=0000", valid_mask, out_we);
    end else passed++;
    fill(26'h55);
    tick();
    in_valid = 1'b0;
    total++;
    if (out_we !== 4'b0100 || out_tag !== 26'h55 || rr_ptr !== rr_before ||
        dut_snap !== exp_snap()) begin
      $display("FAIL inv_fill: we=%b tag=%h rr=%0d expected we=0100 tag=55 rr=%0d",
               out_we, out_tag, rr_ptr, rr_before);
    end else passed++;
  endtask

  task automatic test_collision();
    fill(26'h66);
    in_sel_en = 1'b1; in_sel = 2'd1; inv_en = 1'b1; inv_idx = 2'd1;
    tick();
    in_valid = 1'b0; in_sel_en = 1'b0; inv_en = 1'b0;
    total++;
    if (out_we !== 4'b0010 || valid_mask[1] !== 1'b1 || dut_snap !== exp_snap()) begin
      $display("FAIL collision: we=%b vmask=%b expected we=0010 vmask[1]=1", out_we, valid_mask);
    end else passed++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    fill(26'h77);
    for (int k = 0; k < 3; k++) begin
      inv_en = (k == 1); inv_idx = 2'd3;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        $display("FAIL stall_ready[%0d]: in_ready=%b expected 0", k, in_ready);
      end else passed++;
      tick();
      total++;
      if (out_we !== '0 || dut_snap !== exp_snap()) begin
        $display("FAIL stall[%0d]: we=%b snap=%h expected we=0000 snap=%h",
                 k, out_we, dut_snap, exp_snap());
      end else passed++;
    end
    inv_en = 1'b0; stall = 1'b0; in_valid = 1'b0;
    total++;
    if (valid_mask[3] !== 1'b0) begin
      $display("FAIL stall_inv: vmask=%b expected bit3=0", valid_mask);
    end else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      in_sel_en = ($urandom_range(0, 3) == 0);
      in_sel    = IW'($urandom_range(0, E - 1));
      inv_en    = ($urandom_range(0, 2) == 0);
      inv_idx   = IW'($urandom_range(0, E - 1));
      in_tag    = TW'($urandom);
      in_data   = {$urandom, $urandom};
      #1;
      total++;
      if (in_ready !== ~stall) begin
        $display("FAIL rand_ready[%0d]: in_ready=%b expected %b", k, in_ready, ~stall);
      end else passed++;
      tick();
      total++;
      if (dut_snap !== exp_snap()) begin
        $display("FAIL rand[%0d]: snap=%h expected %h", k, dut_snap, exp_snap());
      end else passed++;
    end
    in_valid = 1'b0; stall = 1'b0; in_sel_en = 1'b0; inv_en = 1'b0;
  endtask

  task automatic test_async_reset();
    fill(26'hA1); tick();
    fill(26'hA2); tick();
    // An out_we pulse is live here; reset lands between edges.
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (dut_snap !== '0) begin
      $display("FAIL async_reset: outputs=%h expected all zero", dut_snap);
    end else passed++;
    in_valid = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_we !== '0 || dut_snap !== exp_snap()) begin
      $display("FAIL post_reset_idle: we=%b snap=%h expected we=0000", out_we, dut_snap);
    end else passed++;
    fill(26'hB0);
    tick();
    in_valid = 1'b0;
    total++;
    if (out_we !== 4'b0001 || out_idx !== '0 || dut_snap !== exp_snap()) begin
      $display("FAIL post_reset_fill: we=%b idx=%0d expected we=0001 idx=0", out_we, out_idx);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_fill4();
    test_wrap();
    test_inv_fill();
    test_collision();
    test_stall();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
